// File: rtl/md_writeback_arbiter.sv
// Mult/div writeback arbiter: captures MD results, shares the regfile write port with the W stage,
// and raises decode stalls on hazards against the in-flight MD destination. Optional: MDWB_FORWARD_EN.
module md_writeback_arbiter #(
    parameter int STARVE_MAX   = 4,
    parameter int RSTATUS_REG  = 30,
    parameter int MUL_EXC_CODE = 4,
    parameter int DIV_EXC_CODE = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        md_start,
    input  logic        md_start_div,
    input  logic [4:0]  md_rd,
    input  logic        md_ready,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        w_we,
    input  logic [4:0]  w_rd,
    input  logic [31:0] w_data,
    input  logic [4:0]  dec_src_a,
    input  logic [4:0]  dec_src_b,
    input  logic        dec_is_md,
`ifdef MDWB_FORWARD_EN
    output logic        fwd_a_sel,
    output logic        fwd_b_sel,
    output logic [31:0] fwd_data,
`endif
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        md_busy,
    output logic        stall
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t         state_q, state_d;
    logic [4:0]     busyRd_q, busyRd_d;
    logic           busyDiv_q, busyDiv_d;
    logic [4:0]     holdTgt_q, holdTgt_d;
    logic [31:0]    holdVal_q, holdVal_d;
    logic           holdExc_q, holdExc_d;
    logic [CW-1:0]  starveCnt_q, starveCnt_d;

    logic [4:0]     runTgt;
    logic [31:0]    runVal;
    logic           runValid;
    logic           holdValid;
    logic           mdWe;
    logic [4:0]     mdReg;
    logic [31:0]    mdData;
    logic           hazA, hazB, starved, fwdOk;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            busyRd_q    <= '0;
            busyDiv_q   <= 1'b0;
            holdTgt_q   <= '0;
            holdVal_q   <= '0;
            holdExc_q   <= 1'b0;
            starveCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busyRd_q    <= busyRd_d;
            busyDiv_q   <= busyDiv_d;
            holdTgt_q   <= holdTgt_d;
            holdVal_q   <= holdVal_d;
            holdExc_q   <= holdExc_d;
            starveCnt_q <= starveCnt_d;
        end
    end

    // Exceptions redirect the write to the status register; a plain result to r0 is dropped.
    assign runTgt    = md_exception ? 5'(RSTATUS_REG) : busyRd_q;
    assign runVal    = md_exception ? (busyDiv_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE)) : md_result;
    assign runValid  = md_exception | (busyRd_q != 5'd0);
    assign holdValid = holdExc_q | (holdTgt_q != 5'd0);

    always_comb begin
        state_d     = state_q;
        busyRd_d    = busyRd_q;
        busyDiv_d   = busyDiv_q;
        holdTgt_d   = holdTgt_q;
        holdVal_d   = holdVal_q;
        holdExc_d   = holdExc_q;
        starveCnt_d = starveCnt_q;
        mdWe        = 1'b0;
        mdReg       = '0;
        mdData      = '0;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d   = RUN;
                    busyRd_d  = md_rd;
                    busyDiv_d = md_start_div;
                end
            end
            RUN: begin
                if (md_ready) begin
                    if (!w_we) begin
                        mdWe    = runValid;
                        mdReg   = runTgt;
                        mdData  = runVal;
                        state_d = IDLE;
                    end else begin
                        state_d   = HOLD;
                        holdTgt_d = runTgt;
                        holdVal_d = runVal;
                        holdExc_d = md_exception;
                    end
                end
            end
            HOLD: begin
                if (!w_we) begin
                    mdWe        = holdValid;
                    mdReg       = holdTgt_q;
                    mdData      = holdVal_q;
                    state_d     = IDLE;
                    starveCnt_d = '0;
                end else if (starveCnt_q != CW'(STARVE_MAX)) begin
                    starveCnt_d = starveCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hazA    = (busyRd_q != 5'd0) && (dec_src_a == busyRd_q);
    assign hazB    = (busyRd_q != 5'd0) && (dec_src_b == busyRd_q);
    assign starved = (state_q == HOLD) && (starveCnt_q == CW'(STARVE_MAX));

`ifdef MDWB_FORWARD_EN
    assign fwdOk     = (state_q == HOLD) && !holdExc_q;
    assign fwd_a_sel = !reset && fwdOk && hazA;
    assign fwd_b_sel = !reset && fwdOk && hazB;
    assign fwd_data  = (!reset && fwdOk) ? holdVal_q : 32'd0;
`else
    assign fwdOk = 1'b0;
`endif

    // W-stage write always wins the port; outputs are forced quiet while reset is asserted.
    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        if (!reset) begin
            if (w_we) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = w_rd;
                data_writeReg    = w_data;
            end else if (mdWe) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = mdReg;
                data_writeReg    = mdData;
            end
        end
    end

    assign md_busy = !reset && (state_q != IDLE);
    assign stall   = !reset && ((md_busy && (dec_is_md || ((hazA || hazB) && !fwdOk))) || starved);

endmodule

// File: tb/tb_md_writeback_arbiter.sv
// Directed self-checking bench for md_writeback_arbiter; expectations adapt when MDWB_FORWARD_EN is defined.
module tb_md_writeback_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        md_start, md_start_div, md_ready, md_exception, w_we, dec_is_md;
    logic [4:0]  md_rd, w_rd, dec_src_a, dec_src_b;
    logic [31:0] md_result, w_data;
    logic        ctrl_writeEnable, md_busy, stall;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
`ifdef MDWB_FORWARD_EN
    logic        fwd_a_sel, fwd_b_sel;
    logic [31:0] fwd_data;
`endif

    int checkCount = 0;
    int errorCount = 0;

    md_writeback_arbiter dut (
        .clock(clock), .reset(reset),
        .md_start(md_start), .md_start_div(md_start_div), .md_rd(md_rd),
        .md_ready(md_ready), .md_result(md_result), .md_exception(md_exception),
        .w_we(w_we), .w_rd(w_rd), .w_data(w_data),
        .dec_src_a(dec_src_a), .dec_src_b(dec_src_b), .dec_is_md(dec_is_md),
`ifdef MDWB_FORWARD_EN
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .fwd_data(fwd_data),
`endif
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .md_busy(md_busy), .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's worth of MD and W-stage inputs, then let the combinational outputs settle.
    task automatic applyStimulus(input logic start, input logic isDiv, input logic [4:0] rd,
                                 input logic ready, input logic [31:0] result, input logic exc,
                                 input logic we, input logic [4:0] wrd, input logic [31:0] wdata);
        md_start = start; md_start_div = isDiv; md_rd = rd;
        md_ready = ready; md_result = result; md_exception = exc;
        w_we = we; w_rd = wrd; w_data = wdata;
        #2;
    endtask

    task automatic setDecode(input logic [4:0] a, input logic [4:0] b, input logic isMd);
        dec_src_a = a; dec_src_b = b; dec_is_md = isMd;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic checkWrite(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
        checkOutput({tag, "_we"}, 32'(ctrl_writeEnable), 32'(we));
        checkOutput({tag, "_reg"}, 32'(ctrl_writeReg), 32'(rd));
        checkOutput({tag, "_data"}, data_writeReg, d);
    endtask

    initial begin
        reset = 1'b1;
        setDecode(5'd0, 5'd0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd3, 32'h11);
        checkWrite("rst_port", 0, 0, 0);
        checkOutput("rst_busy", 32'(md_busy), 0);
        tick;
        tick;

        // Reset held two cycles while an op is in flight discards it
        reset = 1'b0;
        applyStimulus(1, 0, 5'd6, 0, 0, 0, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("run_busy", 32'(md_busy), 1);
        reset = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(md_busy), 0);
        tick;
        tick;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 1, 32'h55, 0, 0, 0, 0);
        checkOutput("postrst_busy", 32'(md_busy), 0);
        checkWrite("postrst_ready", 0, 0, 0);
        tick;

        // mult rd=5, port free: same-cycle write
        applyStimulus(1, 0, 5'd5, 0, 0, 0, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 0, 1, 32'h42, 0, 0, 0, 0);
        checkWrite("mul_direct", 1, 5'd5, 32'h42);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mul_idle_busy", 32'(md_busy), 0);
        checkWrite("mul_idle", 0, 0, 0);
        tick;

        // div rd=7 blocked by two W-stage writes
        applyStimulus(1, 1, 5'd7, 0, 0, 0, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 0, 1, 32'h77, 0, 1, 5'd3, 32'hAAAA);
        checkWrite("div_w1", 1, 5'd3, 32'hAAAA);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd3, 32'hBBBB);
        checkWrite("div_w2", 1, 5'd3, 32'hBBBB);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkWrite("div_held", 1, 5'd7, 32'h77);
        tick;

        // Exceptions go to r30 with the div/mult code
        applyStimulus(1, 1, 5'd9, 0, 0, 0, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 0, 1, 32'h99, 1, 0, 0, 0);
        checkWrite("div_exc", 1, 5'd30, 32'd5);
        tick;
        applyStimulus(1, 0, 5'd9, 0, 0, 0, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 0, 1, 32'h99, 1, 0, 0, 0);
        checkWrite("mul_exc", 1, 5'd30, 32'd4);
        tick;

        // RAW hazard on r8 lasts through the write cycle
        setDecode(5'd0, 5'd8, 1'b0);
        applyStimulus(1, 0, 5'd8, 0, 0, 0, 0, 0, 0);
        checkOutput("haz_idle_stall", 32'(stall), 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("haz_run_stall", 32'(stall), 1);
        tick;
        applyStimulus(0, 0, 0, 1, 32'h88, 0, 1, 5'd4, 32'h44);
        checkOutput("haz_ready_stall", 32'(stall), 1);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkWrite("haz_write", 1, 5'd8, 32'h88);
`ifdef MDWB_FORWARD_EN
        checkOutput("haz_write_stall", 32'(stall), 0);
`else
        checkOutput("haz_write_stall", 32'(stall), 1);
`endif
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("haz_clear_stall", 32'(stall), 0);
        tick;

        // r0 destination: no hazard, result dropped; MD in decode still stalls
        setDecode(5'd0, 5'd0, 1'b0);
        applyStimulus(1, 0, 5'd0, 0, 0, 0, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r0_stall", 32'(stall), 0);
        dec_is_md = 1'b1;
        #1;
        checkOutput("r0_md_stall", 32'(stall), 1);
        dec_is_md = 1'b0;
        tick;
        applyStimulus(0, 0, 0, 1, 32'h33, 0, 0, 0, 0);
        checkWrite("r0_drop", 0, 0, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r0_busy", 32'(md_busy), 0);
        tick;

        // Starvation: four HOLD cycles with w_we=1 saturate the counter
        applyStimulus(1, 0, 5'd10, 0, 0, 0, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 0, 1, 32'h1234, 0, 1, 5'd2, 32'h22);
        checkOutput("st_run_stall", 32'(stall), 0);
`ifdef MDWB_FORWARD_EN
        checkOutput("st_run_fwd", fwd_data, 0);
`endif
        tick;
        setDecode(5'd10, 5'd0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd2, 32'h22);
`ifdef MDWB_FORWARD_EN
        checkOutput("fwd_stall", 32'(stall), 0);
        checkOutput("fwd_a_sel", 32'(fwd_a_sel), 1);
        checkOutput("fwd_b_sel", 32'(fwd_b_sel), 0);
        checkOutput("fwd_data", fwd_data, 32'h1234);
`else
        checkOutput("hold_haz_stall", 32'(stall), 1);
`endif
        tick;
        setDecode(5'd0, 5'd0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd2, 32'h22);
        checkOutput("st_h2_stall", 32'(stall), 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd2, 32'h22);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd2, 32'h22);
        checkOutput("st_h4_stall", 32'(stall), 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd2, 32'h22);
        checkOutput("st_h5_stall", 32'(stall), 1);
        checkWrite("st_h5", 1, 5'd2, 32'h22);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("st_drain_stall", 32'(stall), 1);
        checkWrite("st_drain", 1, 5'd10, 32'h1234);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("st_after_stall", 32'(stall), 0);
        checkOutput("st_after_busy", 32'(md_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
